icache_set_refill: RTL and testbench
====================================

// Module: icache_set_refill
//
// PURPOSE
// One set of an E-way set-associative instruction cache with true-LRU replacement.
// Refill is parametrised: the block arrives over RepW-bit beats.
// Adds per-way valid bits, synchronous Flush, and abort of an interrupted refill.
// Instantiated once per set by the I-cache top; the top drives ActiveSet from the index decode.
//
// PARAMETERS
// B          64  block size in bytes (power of 2, >=8)
// NumTagBits 26  tag width
// E           4  ways (power of 2, >=2)
// RepW       64  refill beat width in bits (32/64/128, divides B*8)
//
// PORTS
// clk          in   1              clock, rising edge
// reset        in   1              asynchronous, active-low reset
// ActiveSet    in   1              this set is addressed this cycle
// RepEnable    in   1              refill data valid on RepWord
// Flush        in   1              invalidate all ways (synchronous)
// Block        in   $clog2(B)      byte offset; [1:0] ignored
// Tag          in   NumTagBits     lookup / refill tag
// RepWord      in   RepW           refill beat, beat k = block bits [k*RepW +: RepW]
// Data         out  32             word at Block offset of hit way; 0 on miss
// CacheMiss    out  1              1 unless ActiveSet & some valid way tag-matches
// RefillActive out  1              FSM in FILL
//
// BEHAVIOUR
// - Reset (reset=0, async): all valid=0; Age[i]=E-1-i; FSM=IDLE; BeatCnt=0.
//   Data=0, CacheMiss=1, RefillActive=0.
// - Lookup is combinational, zero latency.
//   Hit = ActiveSet & Valid[w] & (TagArr[w]==Tag) for exactly one w.
// - On a hit cycle in IDLE with Flush=0: at the clock edge, Age[w]<=0.
//   Every way with Age < old Age[w] increments. Ages always form a permutation of 0..E-1.
// - Victim: lowest-index invalid way if any, else the way with Age==E-1. Computed combinationally.
// - FSM IDLE: if ActiveSet & RepEnable & CacheMiss & !Flush:
//   - Latch Victim and Tag.
//   - Clear Valid[Victim].
//   - Write beat 0 (RepWord) into the victim.
//   - If NBeats=B*8/RepW > 1: BeatCnt<=1 and go to FILL; else complete.
// - FSM FILL: each cycle with ActiveSet & RepEnable, write RepWord into beat BeatCnt.
//   - When BeatCnt==NBeats-1: complete. Set Valid, write the latched tag, do the LRU update
//     as for a hit on Victim, BeatCnt<=0, go to IDLE.
//   - Hit is visible the cycle after the last beat, so a fill spans NBeats cycles.
// - Abort: in FILL, if ActiveSet=0 or RepEnable=0 -> IDLE, BeatCnt<=0.
//   Victim stays invalid; ages unchanged.
// - Tag changes during FILL are ignored (latched tag is used). CacheMiss stays 1 throughout FILL.
// - Flush has top priority:
//   - At the edge, all Valid<=0, Age[i]<=E-1-i, FSM->IDLE.
//   - No lookup or LRU update that cycle.
// - ActiveSet=0: no state change except Flush and abort; outputs read as a miss.
// - BeatCnt width $clog2(NBeats)+1; never wraps past NBeats-1.
//
// STRUCTURE
// - Package icache_pkg:
//   - typedef enum logic {IDLE, FILL} refill_state_t
//   - function nbeats(B,RepW)
// - Sub-module icache_lru_ages #(E): holds Age[E], inputs Touch/TouchWay/Init, outputs Age and the MaxWay index.
// - Data/tag/valid arrays and FSM stay in this module.
//
// TESTING
// - After reset, ActiveSet=1 Tag=500 Block=0 -> CacheMiss=1, Data=0, ages {3,2,1,0}.
// - Fill 4 ways with tags 500,600,700,800 (8 beats of 64b each):
//   - Data==block[31:0], CacheMiss=0 after the 8th beat.
//   - Ages end as Age[i]==3-i.
// - Read tags 800,700,600,500 at Block=4,8,12,16 -> correct words hit; Age[i]==i.
// - Tag 1000 refill -> replaces way3 (age 3); ages {1,2,3,0}.
//   Then hit on way1 tag -> ages {2,0,3,1}.
// - Drop RepEnable after beat 3 of a fill -> RefillActive=0, target way invalid.
//   Next miss refills that same way first.
// - Flush mid-FILL, and reset asserted mid-FILL -> all miss, ages {3,2,1,0}, FSM IDLE.
//   Repeat with RepW=32 (16 beats) and RepW=128 (4 beats).

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// icache_pkg : refill FSM state type and refill beat-count helper.  Rev 1.0
//----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} refill_state_t;

  function automatic int nbeats(input int b, input int repw);
    return (b * 8) / repw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_lru_ages.sv
`default_nettype none
//----------------------------------------------------------------------------
// icache_lru_ages : true-LRU age permutation for one E-way set.  Rev 1.0
//----------------------------------------------------------------------------
module icache_lru_ages
  import icache_pkg::*;
#(
  parameter int E = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          touch,
  input  logic [$clog2(E)-1:0]          touch_way,
  input  logic                          init,
  output logic [E-1:0][$clog2(E)-1:0]   age,
  output logic [$clog2(E)-1:0]          max_way
);

  localparam int AW = $clog2(E);

  logic [E-1:0][AW-1:0] age_q, age_d;

  // Touched way becomes youngest; only ways younger than it age by one.
  always_comb begin
    age_d = age_q;
    if (init) begin
      for (int i = 0; i < E; i++) age_d[i] = AW'(E - 1 - i);
    end else if (touch) begin
      for (int i = 0; i < E; i++) begin
        if (AW'(i) == touch_way)
          age_d[i] = '0;
        else if (age_q[i] < age_q[touch_way])
          age_d[i] = age_q[i] + AW'(1);
      end
    end
  end

  always_comb begin
    max_way = '0;
    for (int i = 0; i < E; i++)
      if (age_q[i] == AW'(E - 1)) max_way = AW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < E; i++) age_q[i] <= AW'(E - 1 - i);
    end else begin
      age_q <= age_d;
    end
  end

  assign age = age_q;

endmodule
`default_nettype wire

// File: rtl/icache_set_refill.sv
`default_nettype none
//----------------------------------------------------------------------------
// icache_set_refill : one LRU set of the I-cache with beat-wise refill.  Rev 1.0
//----------------------------------------------------------------------------
module icache_set_refill
  import icache_pkg::*;
#(
  parameter int B          = 64,
  parameter int NumTagBits = 26,
  parameter int E          = 4,
  parameter int RepW       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ActiveSet,
  input  logic                  RepEnable,
  input  logic                  Flush,
  input  logic [$clog2(B)-1:0]  Block,
  input  logic [NumTagBits-1:0] Tag,
  input  logic [RepW-1:0]       RepWord,
  output logic [31:0]           Data,
  output logic                  CacheMiss,
  output logic                  RefillActive
);

  localparam int NBEATS = nbeats(B, RepW);
  localparam int WAY_W  = $clog2(E);
  localparam int BEAT_W = $clog2(NBEATS) + 1;
  localparam int OFF_W  = $clog2(B);

  refill_state_t         state_q, state_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [NumTagBits-1:0] fill_tag_q, fill_tag_d;
  logic [E-1:0]          valid_q, valid_d;
  logic [NumTagBits-1:0] tag_arr_q [E];
  logic [NumTagBits-1:0] tag_arr_d [E];
  logic [B*8-1:0]        data_arr_q [E];
  logic [B*8-1:0]        data_arr_d [E];

  logic                  hit;
  logic [WAY_W-1:0]      hit_way, victim_way, lru_max_way, lru_touch_way;
  logic                  lru_touch, lru_init;
  logic [E-1:0][WAY_W-1:0] ages_unused;
  logic                  unused_block_lsbs;

  assign unused_block_lsbs = ^Block[1:0];

  icache_lru_ages #(.E(E)) u_lru (
    .clk       (clk),
    .reset     (reset),
    .touch     (lru_touch),
    .touch_way (lru_touch_way),
    .init      (lru_init),
    .age       (ages_unused),
    .max_way   (lru_max_way)
  );

  // The victim way is invalid while it refills, so gating by IDLE keeps the miss steady.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = E - 1; w >= 0; w--) begin
      if (ActiveSet && (state_q == IDLE) && valid_q[w] && (tag_arr_q[w] == Tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim_way = lru_max_way;
    for (int w = E - 1; w >= 0; w--)
      if (!valid_q[w]) victim_way = WAY_W'(w);
  end

  assign Data         = hit ? data_arr_q[hit_way][{Block[OFF_W-1:2], 5'b00000} +: 32] : '0;
  assign CacheMiss    = !hit;
  assign RefillActive = (state_q == FILL);

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    victim_d      = victim_q;
    fill_tag_d    = fill_tag_q;
    valid_d       = valid_q;
    tag_arr_d     = tag_arr_q;
    data_arr_d    = data_arr_q;
    lru_touch     = 1'b0;
    lru_touch_way = hit_way;
    lru_init      = 1'b0;

    if (Flush) begin
      valid_d    = '0;
      lru_init   = 1'b1;
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            lru_touch = 1'b1;
          end else if (ActiveSet && RepEnable) begin
            victim_d                          = victim_way;
            fill_tag_d                        = Tag;
            valid_d[victim_way]               = 1'b0;
            data_arr_d[victim_way][0 +: RepW] = RepWord;
            if (NBEATS > 1) begin
              beat_cnt_d = BEAT_W'(1);
              state_d    = FILL;
            end else begin
              valid_d[victim_way]   = 1'b1;
              tag_arr_d[victim_way] = Tag;
              lru_touch             = 1'b1;
              lru_touch_way         = victim_way;
            end
          end
        end
        FILL: begin
          if (ActiveSet && RepEnable) begin
            data_arr_d[victim_q][beat_cnt_q*RepW +: RepW] = RepWord;
            if (beat_cnt_q == BEAT_W'(NBEATS - 1)) begin
              valid_d[victim_q]   = 1'b1;
              tag_arr_d[victim_q] = fill_tag_q;
              lru_touch           = 1'b1;
              lru_touch_way       = victim_q;
              beat_cnt_d          = '0;
              state_d             = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
          end else begin
            // Interrupted refill: leave the victim invalid and the ages untouched.
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      victim_q   <= '0;
      fill_tag_q <= '0;
      valid_q    <= '0;
      for (int w = 0; w < E; w++) begin
        tag_arr_q[w]  <= '0;
        data_arr_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      victim_q   <= victim_d;
      fill_tag_q <= fill_tag_d;
      valid_q    <= valid_d;
      tag_arr_q  <= tag_arr_d;
      data_arr_q <= data_arr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_set_refill.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_icache_set_refill : three set instances (32/64/128-bit beats) vs. a recency-list model.
//----------------------------------------------------------------------------
module tb_icache_set_refill;

  localparam int NT = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rep_en, flush;
  logic [2:0]    act;
  logic [5:0]    blk;
  logic [NT-1:0] tag;
  logic [127:0]  rep_word;
  logic [31:0]   data_o [3];
  logic [2:0]    miss_o, ract_o;

  icache_set_refill #(.B(64), .NumTagBits(NT), .E(4), .RepW(32)) u_d32 (
    .clk(clk), .reset(rst_n), .ActiveSet(act[0]), .RepEnable(rep_en), .Flush(flush),
    .Block(blk), .Tag(tag), .RepWord(rep_word[31:0]), .Data(data_o[0]),
    .CacheMiss(miss_o[0]), .RefillActive(ract_o[0]));
  icache_set_refill #(.B(64), .NumTagBits(NT), .E(4), .RepW(64)) u_d64 (
    .clk(clk), .reset(rst_n), .ActiveSet(act[1]), .RepEnable(rep_en), .Flush(flush),
    .Block(blk), .Tag(tag), .RepWord(rep_word[63:0]), .Data(data_o[1]),
    .CacheMiss(miss_o[1]), .RefillActive(ract_o[1]));
  icache_set_refill #(.B(64), .NumTagBits(NT), .E(4), .RepW(128)) u_d128 (
    .clk(clk), .reset(rst_n), .ActiveSet(act[2]), .RepEnable(rep_en), .Flush(flush),
    .Block(blk), .Tag(tag), .RepWord(rep_word), .Data(data_o[2]),
    .CacheMiss(miss_o[2]), .RefillActive(ract_o[2]));

  // Model: ord[d][k] is the way at recency rank k (0 = most recent), so age == rank.
  int            ord [3][4];
  bit            mv  [3][4];
  logic [NT-1:0] mt  [3][4];
  logic [511:0]  mb  [3][4];
  int            NB  [3] = '{16, 8, 4};
  int            RW  [3] = '{32, 64, 128};
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    int            d;
    bit            a;
    logic [NT-1:0] t;
    logic [5:0]    b;
    bit            exp_miss;
    logic [31:0]   exp_data;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] mk_word(logic [NT-1:0] t, int j);
    return {t[15:0], 8'hC3, 8'(j)};
  endfunction

  function automatic logic [511:0] mk_block(logic [NT-1:0] t);
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[j*32 +: 32] = mk_word(t, j);
    return b;
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        ord[d][k] = 3 - k;
        mv[d][k]  = 1'b0;
      end
  endfunction

  function automatic int m_age(int d, int w);
    for (int k = 0; k < 4; k++) if (ord[d][k] == w) return k;
    return -1;
  endfunction

  function automatic void m_touch(int d, int w);
    int p;
    p = m_age(d, w);
    for (int k = p; k > 0; k--) ord[d][k] = ord[d][k-1];
    ord[d][0] = w;
  endfunction

  function automatic int m_hitway(int d, logic [NT-1:0] t);
    for (int w = 0; w < 4; w++) if (mv[d][w] && mt[d][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(int d);
    for (int w = 0; w < 4; w++) if (!mv[d][w]) return w;
    return ord[d][3];
  endfunction

  function automatic int dut_age(int d, int w);
    case (d)
      0:       return int'(u_d32.u_lru.age_q[w]);
      1:       return int'(u_d64.u_lru.age_q[w]);
      default: return int'(u_d128.u_lru.age_q[w]);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ages(int d, string nm);
    for (int w = 0; w < 4; w++)
      chk($sformatf("%s d%0d age[%0d]", nm, d, w), 64'(dut_age(d, w)), 64'(m_age(d, w)));
  endtask

  task automatic check_const_ages(int d, string nm, int a0, int a1, int a2, int a3);
    int e [4];
    e = '{a0, a1, a2, a3};
    for (int w = 0; w < 4; w++)
      chk($sformatf("%s d%0d age[%0d]", nm, d, w), 64'(dut_age(d, w)), 64'(e[w]));
  endtask

  task automatic check_look(int d, string nm);
    int w;
    bit h;
    w = m_hitway(d, tag);
    h = act[d] && (w >= 0);
    chk({nm, " miss"}, 64'(miss_o[d]), 64'(!h));
    chk({nm, " data"}, 64'(data_o[d]), h ? 64'(mb[d][w][blk[5:2]*32 +: 32]) : 64'd0);
  endtask

  task automatic lookup(int d, logic [NT-1:0] t, logic [5:0] b, bit a);
    int w;
    act = '0; act[d] = a; tag = t; blk = b; rep_en = 1'b0; flush = 1'b0;
    #1;
    check_look(d, $sformatf("lookup d%0d tag %0d", d, t));
    chk("lookup ract", 64'(ract_o[d]), 64'd0);
    w = m_hitway(d, t);
    if (a && w >= 0) m_touch(d, w);
    cyc();
    check_ages(d, "lookup");
  endtask

  // Delivers n beats of tag t; flush_at >= 0 raises Flush on that beat instead.
  task automatic fill(int d, logic [NT-1:0] t, int n, int flush_at);
    logic [511:0] bd;
    int v;
    bit flushed;
    bd = mk_block(t);
    v = m_victim(d);
    flushed = 1'b0;
    for (int k = 0; k < n; k++) begin
      act = '0; act[d] = 1'b1; rep_en = 1'b1; blk = 6'($urandom_range(0, 63));
      flush = (k == flush_at);
      tag = (k == 0) ? t : (t ^ 26'h2000000);
      rep_word = 128'(bd >> (k * RW[d]));
      #1;
      chk($sformatf("fill d%0d beat%0d miss", d, k), 64'(miss_o[d]), 64'd1);
      chk($sformatf("fill d%0d beat%0d ract", d, k), 64'(ract_o[d]), 64'(k > 0));
      cyc();
      if (k == flush_at) begin
        flushed = 1'b1;
        break;
      end
    end
    flush = 1'b0;
    if (flushed) begin
      m_reset();
    end else if (n == NB[d]) begin
      mv[d][v] = 1'b1; mt[d][v] = t; mb[d][v] = bd;
      m_touch(d, v);
    end else begin
      mv[d][v] = 1'b0;
      if ($urandom_range(0, 1) != 0) rep_en = 1'b0; else act[d] = 1'b0;
      #1;
      chk("abort cycle ract", 64'(ract_o[d]), 64'd1);
      cyc();
    end
    rep_en = 1'b0;
    chk($sformatf("fill d%0d end ract", d), 64'(ract_o[d]), 64'd0);
    check_ages(d, "fill");
  endtask

  task automatic flush_cycle(int d, logic [NT-1:0] t);
    act = '0; act[d] = 1'($urandom_range(0, 1)); rep_en = 1'($urandom_range(0, 1));
    flush = 1'b1; tag = t; blk = 6'($urandom_range(0, 63));
    #1;
    check_look(d, "flush cycle");
    cyc();
    flush = 1'b0; rep_en = 1'b0;
    m_reset();
    chk("flush ract", 64'(ract_o[d]), 64'd0);
    check_ages(d, "flush");
  endtask

  task automatic reset_mid_fill(int d, logic [NT-1:0] t);
    logic [511:0] bd;
    bd = mk_block(t);
    act = '0; act[d] = 1'b1; rep_en = 1'b1; tag = t;
    for (int k = 0; k < 3; k++) begin
      rep_word = 128'(bd >> (k * RW[d]));
      cyc();
    end
    chk("pre-reset ract", 64'(ract_o[d]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("reset ract", 64'(ract_o), 64'd0);
    chk("reset miss", 64'(miss_o), 64'h7);
    chk("reset data", 64'(data_o[d]), 64'd0);
    for (int dd = 0; dd < 3; dd++) check_const_ages(dd, "async reset", 3, 2, 1, 0);
    #2 rst_n = 1'b1;
    act = '0; rep_en = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int hw;
    logic [NT-1:0] t;

    rst_n = 1'b0; act = '0; rep_en = 1'b0; flush = 1'b0; blk = '0; tag = '0; rep_word = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Reset state seen through a lookup.
    act[1] = 1'b1; tag = 500; blk = 0;
    #1;
    chk("reset miss", 64'(miss_o[1]), 64'd1);
    chk("reset data", 64'(data_o[1]), 64'd0);
    chk("reset ract", 64'(ract_o[1]), 64'd0);
    check_const_ages(1, "reset", 3, 2, 1, 0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      fill(1, 26'(500 + 100 * i), 8, -1);
      act = '0; act[1] = 1'b1; tag = 26'(500 + 100 * i); blk = 0;
      #1;
      chk("fill word0", 64'(data_o[1]), 64'(mk_word(26'(500 + 100 * i), 0)));
      chk("fill hit", 64'(miss_o[1]), 64'd0);
      cyc();
    end
    check_const_ages(1, "after 4 fills", 3, 2, 1, 0);

    tbl[0] = '{d:1, a:1'b1, t:800, b:4,  exp_miss:1'b0, exp_data:mk_word(800, 1)};
    tbl[1] = '{d:1, a:1'b1, t:700, b:8,  exp_miss:1'b0, exp_data:mk_word(700, 2)};
    tbl[2] = '{d:1, a:1'b1, t:600, b:12, exp_miss:1'b0, exp_data:mk_word(600, 3)};
    tbl[3] = '{d:1, a:1'b1, t:500, b:16, exp_miss:1'b0, exp_data:mk_word(500, 4)};
    tbl[4] = '{d:1, a:1'b1, t:900, b:0,  exp_miss:1'b1, exp_data:32'd0};
    tbl[5] = '{d:1, a:1'b0, t:500, b:16, exp_miss:1'b1, exp_data:32'd0};
    for (int i = 0; i < 6; i++) begin
      act = '0; act[tbl[i].d] = tbl[i].a; tag = tbl[i].t; blk = tbl[i].b;
      #1;
      chk($sformatf("tbl%0d miss", i), 64'(miss_o[tbl[i].d]), 64'(tbl[i].exp_miss));
      chk($sformatf("tbl%0d data", i), 64'(data_o[tbl[i].d]), 64'(tbl[i].exp_data));
      check_look(tbl[i].d, $sformatf("tbl%0d model", i));
      hw = m_hitway(tbl[i].d, tbl[i].t);
      if (tbl[i].a && hw >= 0) m_touch(tbl[i].d, hw);
      cyc();
    end
    check_const_ages(1, "after reads", 0, 1, 2, 3);

    fill(1, 1000, 8, -1);
    check_const_ages(1, "replace lru", 1, 2, 3, 0);
    lookup(1, 600, 0, 1'b1);
    check_const_ages(1, "hit way1", 2, 0, 3, 1);

    fill(1, 1100, 3, -1);
    chk("aborted way invalid", 64'(u_d64.valid_q[2]), 64'd0);
    lookup(1, 700, 0, 1'b1);
    fill(1, 1200, 8, -1);
    chk("refill reuses way", 64'(dut_age(1, 2)), 64'd0);
    lookup(1, 1200, 20, 1'b1);

    for (int d = 0; d < 3; d++) begin
      fill(d, 2000, NB[d], -1);
      fill(d, 2100, NB[d], -1);
      fill(d, 2200, NB[d], 2);
      check_const_ages(d, "flush mid fill", 3, 2, 1, 0);
      lookup(d, 2000, 0, 1'b1);
      lookup(d, 2100, 4, 1'b1);
      fill(d, 2300, NB[d], -1);
      reset_mid_fill(d, 2400);
      lookup(d, 2300, 0, 1'b1);
    end

    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 120; it++) begin
        r = $urandom_range(0, 19);
        t = 26'(500 + 100 * $urandom_range(0, 7));
        hw = m_hitway(d, t);
        if (r < 10 || (r < 18 && hw >= 0))
          lookup(d, t, 6'($urandom_range(0, 63)), $urandom_range(0, 5) != 0);
        else if (r < 14)
          fill(d, t, NB[d], -1);
        else if (r < 17)
          fill(d, t, $urandom_range(1, NB[d] - 1), -1);
        else if (r < 18)
          fill(d, t, NB[d], $urandom_range(1, NB[d] - 1));
        else
          flush_cycle(d, t);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
